// File: rtl/score_digit_driver_if.sv
// score_digit_driver_if: goal/restart inputs and digit/blank/lamp outputs of the foosball scorekeeper
interface score_digit_driver_if;
  logic       goal_left;
  logic       goal_right;
  logic       new_game;
  logic [3:0] left_tens;
  logic [3:0] left_ones;
  logic [3:0] right_tens;
  logic [3:0] right_ones;
  logic       left_darkN;
  logic       right_darkN;
  logic       lamp_test;
  logic       game_over;
  logic       winner;
  modport master (
    output goal_left, goal_right, new_game,
    input  left_tens, left_ones, right_tens, right_ones,
    input  left_darkN, right_darkN, lamp_test, game_over, winner
  );
  modport slave (
    input  goal_left, goal_right, new_game,
    output left_tens, left_ones, right_tens, right_ones,
    output left_darkN, right_darkN, lamp_test, game_over, winner
  );
endinterface

// File: rtl/score_digit_driver.sv
// score_digit_driver: BCD goal counting, lamp test, post-goal lockout and winner blink for a foosball display
module score_digit_driver #(
  parameter int unsigned WIN_SCORE   = 10,
  parameter int unsigned LAMP_CYCLES = 50_000_000,
  parameter int unsigned GOAL_HOLD   = 50_000_000,
  parameter int unsigned BLINK_HALF  = 25_000_000
) (
  input logic                 clk,
  input logic                 resetN,
  score_digit_driver_if.slave bus
);
  typedef enum logic [1:0] {LAMP, PLAY, HOLD, OVER} state_t;
  localparam logic [3:0] WIN_T = 4'(WIN_SCORE / 10);
  localparam logic [3:0] WIN_O = 4'(WIN_SCORE % 10);
  state_t      r_state, w_state;
  logic [31:0] r_cnt, w_cnt;
  logic        r_gl_d, r_gr_d;
  logic [3:0]  r_lt, r_lo, r_rt, r_ro, w_lt, w_lo, w_rt, w_ro;
  logic        r_ldark, r_rdark, r_lamp, r_over, r_win;
  logic        w_ldark, w_rdark, w_lamp, w_over, w_win;
  logic        w_el, w_er, w_lwin, w_rwin;
  logic [3:0]  w_lt_inc, w_lo_inc, w_rt_inc, w_ro_inc;
  assign w_el     = bus.goal_left & ~r_gl_d;
  assign w_er     = bus.goal_right & ~r_gr_d;
  assign w_lo_inc = (r_lo == 4'd9) ? 4'd0 : r_lo + 4'd1;
  assign w_lt_inc = (r_lo == 4'd9) ? r_lt + 4'd1 : r_lt;
  assign w_ro_inc = (r_ro == 4'd9) ? 4'd0 : r_ro + 4'd1;
  assign w_rt_inc = (r_ro == 4'd9) ? r_rt + 4'd1 : r_rt;
  assign w_lwin   = (w_lt_inc == WIN_T) && (w_lo_inc == WIN_O);
  assign w_rwin   = (w_rt_inc == WIN_T) && (w_ro_inc == WIN_O);
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_lt    = r_lt;
    w_lo    = r_lo;
    w_rt    = r_rt;
    w_ro    = r_ro;
    w_ldark = r_ldark;
    w_rdark = r_rdark;
    w_lamp  = r_lamp;
    w_over  = r_over;
    w_win   = r_win;
    if (r_state == LAMP) begin
      w_cnt = r_cnt + 32'd1;
      if (r_cnt == 32'(LAMP_CYCLES - 1)) begin
        w_state = PLAY;
        w_cnt   = '0;
        w_lamp  = 1'b0;
      end
    end else if (bus.new_game) begin
      w_state = PLAY;
      w_cnt   = '0;
      w_lt    = '0;
      w_lo    = '0;
      w_rt    = '0;
      w_ro    = '0;
      w_ldark = 1'b1;
      w_rdark = 1'b1;
      w_over  = 1'b0;
      w_win   = 1'b0;
    end else if (r_state == PLAY) begin
      // both edges in one cycle is an ambiguous sensor event and is dropped
      if (w_el && !w_er) begin
        w_lt    = w_lt_inc;
        w_lo    = w_lo_inc;
        w_cnt   = '0;
        w_state = w_lwin ? OVER : HOLD;
        w_over  = w_lwin;
        w_win   = 1'b0;
      end else if (w_er && !w_el) begin
        w_rt    = w_rt_inc;
        w_ro    = w_ro_inc;
        w_cnt   = '0;
        w_state = w_rwin ? OVER : HOLD;
        w_over  = w_rwin;
        w_win   = w_rwin;
      end
    end else if (r_state == HOLD) begin
      w_cnt = r_cnt + 32'd1;
      if (r_cnt == 32'(GOAL_HOLD - 1)) begin
        w_state = PLAY;
        w_cnt   = '0;
      end
    end else begin
      w_cnt = r_cnt + 32'd1;
      if (r_cnt == 32'(BLINK_HALF - 1)) begin
        w_cnt   = '0;
        w_ldark = r_win ? r_ldark : ~r_ldark;
        w_rdark = r_win ? ~r_rdark : r_rdark;
      end
    end
  end
  always_ff @(posedge clk or negedge resetN)
    if (!resetN) begin
      r_state <= LAMP;
      r_cnt   <= '0;
      r_gl_d  <= 1'b0;
      r_gr_d  <= 1'b0;
      r_lt    <= '0;
      r_lo    <= '0;
      r_rt    <= '0;
      r_ro    <= '0;
      r_ldark <= 1'b1;
      r_rdark <= 1'b1;
      r_lamp  <= 1'b1;
      r_over  <= 1'b0;
      r_win   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_gl_d  <= bus.goal_left;
      r_gr_d  <= bus.goal_right;
      r_lt    <= w_lt;
      r_lo    <= w_lo;
      r_rt    <= w_rt;
      r_ro    <= w_ro;
      r_ldark <= w_ldark;
      r_rdark <= w_rdark;
      r_lamp  <= w_lamp;
      r_over  <= w_over;
      r_win   <= w_win;
    end
  assign bus.left_tens   = r_lt;
  assign bus.left_ones   = r_lo;
  assign bus.right_tens  = r_rt;
  assign bus.right_ones  = r_ro;
  assign bus.left_darkN  = r_ldark;
  assign bus.right_darkN = r_rdark;
  assign bus.lamp_test   = r_lamp;
  assign bus.game_over   = r_over;
  assign bus.winner      = r_win;
endmodule

// File: tb/tb_score_digit_driver.sv
// tb_score_digit_driver: directed stimulus with a cycle-stamped scoreboard checked at falling clock edges
module tb_score_digit_driver;
  typedef struct packed {
    logic [3:0] lt, lo, rt, ro;
    logic       ld, rd, lamp, over, win;
  } obs_t;
  typedef struct {
    int   cyc;
    bit   sel;
    obs_t exp;
    int   id;
  } chk_t;
  logic clk = 1'b0;
  logic resetN;
  chk_t q[$];
  int   ncyc = 0, nid = 0, n_chk = 0, n_fail = 0;
  bit   done = 1'b0;
  chk_t e;
  obs_t got;
  score_digit_driver_if b0();
  score_digit_driver_if b1();
  score_digit_driver #(.WIN_SCORE(3), .LAMP_CYCLES(4), .GOAL_HOLD(3), .BLINK_HALF(2))
    dut0 (.clk(clk), .resetN(resetN), .bus(b0));
  score_digit_driver #(.WIN_SCORE(12), .LAMP_CYCLES(4), .GOAL_HOLD(3), .BLINK_HALF(2))
    dut1 (.clk(clk), .resetN(resetN), .bus(b1));
  always #5 clk = ~clk;
  function automatic obs_t mk(input logic [3:0] lt, lo, rt, ro, input logic ld, rd, lamp, over, win);
    return '{lt, lo, rt, ro, ld, rd, lamp, over, win};
  endfunction
  function automatic obs_t snap(input bit s);
    return s ? mk(b1.left_tens, b1.left_ones, b1.right_tens, b1.right_ones, b1.left_darkN,
                  b1.right_darkN, b1.lamp_test, b1.game_over, b1.winner)
             : mk(b0.left_tens, b0.left_ones, b0.right_tens, b0.right_ones, b0.left_darkN,
                  b0.right_darkN, b0.lamp_test, b0.game_over, b0.winner);
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input bit s, input obs_t x);
    q.push_back('{cyc: ncyc + 1, sel: s, exp: x, id: nid});
    nid++;
  endtask
  always @(negedge clk) begin
    ncyc++;
    while (q.size() > 0 && q[0].cyc == ncyc) begin
      e = q.pop_front();
      got = snap(e.sel);
      n_chk++;
      if (got !== e.exp) begin
        n_fail++;
        $display("FAIL chk%0d dut%0d: got lt=%0d lo=%0d rt=%0d ro=%0d ldN=%b rdN=%b lamp=%b over=%b win=%b; want lt=%0d lo=%0d rt=%0d ro=%0d ldN=%b rdN=%b lamp=%b over=%b win=%b",
                 e.id, e.sel, got.lt, got.lo, got.rt, got.ro, got.ld, got.rd, got.lamp, got.over, got.win,
                 e.exp.lt, e.exp.lo, e.exp.rt, e.exp.ro, e.exp.ld, e.exp.rd, e.exp.lamp, e.exp.over, e.exp.win);
      end
    end
    if (done) begin
      if (q.size() != 0) begin
        n_fail++;
        $display("FAIL pending: %0d checks never reached, want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1);
  end
  initial begin
    resetN = 1'b0;
    b0.goal_left = 1'b0; b0.goal_right = 1'b0; b0.new_game = 1'b0;
    b1.goal_left = 1'b0; b1.goal_right = 1'b0; b1.new_game = 1'b0;
    step(); step();
    push(0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    push(1, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    resetN = 1'b1;
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0)); b0.goal_left = 1'b1;
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0)); b0.goal_left = 1'b0;
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    b0.goal_left = 1'b1;
    step(); push(0, mk(0, 1, 0, 0, 1, 1, 0, 0, 0)); b0.goal_left = 1'b0;
    step(); b0.goal_left = 1'b1;
    step(); push(0, mk(0, 1, 0, 0, 1, 1, 0, 0, 0)); b0.goal_left = 1'b0;
    step(); push(0, mk(0, 1, 0, 0, 1, 1, 0, 0, 0));
    b0.goal_left = 1'b1;
    step(); push(0, mk(0, 2, 0, 0, 1, 1, 0, 0, 0));
    repeat (9) step();
    push(0, mk(0, 2, 0, 0, 1, 1, 0, 0, 0)); b0.goal_left = 1'b0;
    step();
    b0.goal_left = 1'b1; b0.goal_right = 1'b1;
    step(); push(0, mk(0, 2, 0, 0, 1, 1, 0, 0, 0));
    b0.goal_left = 1'b0; b0.goal_right = 1'b0;
    step();
    b0.goal_right = 1'b1;
    step(); push(0, mk(0, 2, 0, 1, 1, 1, 0, 0, 0)); b0.goal_right = 1'b0;
    repeat (3) step();
    b0.goal_right = 1'b1;
    step(); push(0, mk(0, 2, 0, 2, 1, 1, 0, 0, 0)); b0.goal_right = 1'b0;
    repeat (3) step();
    b0.goal_right = 1'b1;
    step(); push(0, mk(0, 2, 0, 3, 1, 1, 0, 1, 1)); b0.goal_right = 1'b0;
    step(); push(0, mk(0, 2, 0, 3, 1, 1, 0, 1, 1)); b0.goal_left = 1'b1;
    step(); push(0, mk(0, 2, 0, 3, 1, 0, 0, 1, 1)); b0.goal_left = 1'b0;
    step(); push(0, mk(0, 2, 0, 3, 1, 0, 0, 1, 1));
    step(); push(0, mk(0, 2, 0, 3, 1, 1, 0, 1, 1));
    step(); push(0, mk(0, 2, 0, 3, 1, 1, 0, 1, 1));
    b0.goal_left = 1'b1; b0.new_game = 1'b1;
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    b0.new_game = 1'b0; b0.goal_left = 1'b0;
    step(); push(0, mk(0, 0, 0, 0, 1, 1, 0, 0, 0));
    b0.goal_right = 1'b1;
    step(); push(0, mk(0, 0, 0, 1, 1, 1, 0, 0, 0)); b0.goal_right = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      b1.goal_left = 1'b1;
      step(); push(1, mk(0, 4'(i), 0, 0, 1, 1, 0, 0, 0)); b1.goal_left = 1'b0;
      repeat (3) step();
    end
    b1.goal_left = 1'b1;
    step(); push(1, mk(1, 0, 0, 0, 1, 1, 0, 0, 0)); b1.goal_left = 1'b0;
    step();
    resetN = 1'b0;
    push(1, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    push(0, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    step(); push(1, mk(0, 0, 0, 0, 1, 1, 1, 0, 0));
    resetN = 1'b1;
    step();
    done = 1'b1;
  end
endmodule

// File: doc/score_digit_driver.md
Name: score_digit_driver

Overview:
- Sequential scorekeeper for the foosball table: counts goals per player in BCD and drives the per-digit hex nibbles, blank control and lamp-test control into the hex-to-7-segment decoders.
- Sits between the goal-sensor logic (upstream) and four hex-to-7-segment decoder instances (downstream). There are two digits per player.
- Owns game sequencing: power-up lamp test, play, post-goal lockout, and game-over blinking of the winner's digits.

Parameters:
- WIN_SCORE, 10, goals needed to win. Legal range 1..99.
- LAMP_CYCLES, 50_000_000, length of the power-up lamp test in clock cycles. Minimum 1.
- GOAL_HOLD, 50_000_000, lockout after a counted goal in clock cycles. Minimum 1.
- BLINK_HALF, 25_000_000, half-period of the winner blink in clock cycles. Minimum 1.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous, active-low reset.
- goal_left  in  1  left-goal sensor level, synchronous to clk. A rising edge scores for left.
- goal_right  in  1  right-goal sensor level, synchronous to clk. A rising edge scores for right.
- new_game  in  1  one-cycle restart pulse.
- left_tens  out  4  BCD tens digit of the left score.
- left_ones  out  4  BCD ones digit of the left score.
- right_tens  out  4  BCD tens digit of the right score.
- right_ones  out  4  BCD ones digit of the right score.
- left_darkN  out  1  0 blanks both left digits.
- right_darkN  out  1  0 blanks both right digits.
- lamp_test  out  1  1 forces all segments lit.
- game_over  out  1  1 while in GAME_OVER.
- winner  out  1  0 = left, 1 = right. Valid only while game_over = 1.

Behaviour:
- Interface: one clock, clk. Reset resetN is asynchronous and active-low. All outputs are registered.
- Reset values: all digit outputs 0; left_darkN = right_darkN = 1; lamp_test = 1; game_over = 0; winner = 0; state LAMP; counters 0; edge registers 0.
- Edge detection:
  - goal_x_d registers the previous sample of each goal input.
  - An edge is goal_x = 1 and goal_x_d = 0 at a clock edge.
  - goal_x_d updates in every state, so a level held across lockout never scores twice.
- Simultaneous rising edges on both goal inputs in the same cycle are discarded as an ambiguous sensor event. No score change and no state change.
- State LAMP:
  - lamp_test = 1.
  - Counter runs LAMP_CYCLES cycles, then state goes to PLAY and lamp_test = 0 on the same edge.
  - Goals and new_game are ignored.
- State PLAY:
  - A single valid edge increments that player's score at that same clock edge, so the output changes 1 cycle after the input rises.
  - If the new score equals WIN_SCORE, go to GAME_OVER: set winner, set game_over = 1, reset the blink counter.
  - Otherwise go to HOLD.
- State HOLD:
  - All goal edges are ignored.
  - After GOAL_HOLD cycles, return to PLAY.
- State GAME_OVER:
  - Scores are frozen and goals are ignored.
  - The winner's darkN starts at 1 and toggles every BLINK_HALF cycles.
  - The loser's darkN stays 1.
- BCD increment: ones 9 → 0 with tens + 1. Tens never exceeds 9, which is guaranteed by WIN_SCORE ≤ 99.
- new_game in PLAY, HOLD or GAME_OVER:
  - Clears all digits, game_over, winner and all counters.
  - Sets both darkN = 1.
  - Goes to PLAY on that edge.
  - Takes priority over a simultaneous goal edge.
- Reset asserted mid-operation, including mid-blink or mid-hold, immediately restores all reset values.

Test Plan (WIN_SCORE = 3, LAMP_CYCLES = 4, GOAL_HOLD = 3, BLINK_HALF = 2):
1. Release reset → lamp_test = 1 for exactly 4 cycles, then 0. All digits stay 0, both darkN = 1. A goal_left pulse during LAMP leaves left_ones = 0.
2. In PLAY, raise goal_left and hold it high for 10 cycles → left_ones = 1 exactly one cycle after the rise, and no further increment. A second rise arriving 2 cycles after the counted goal, inside HOLD, is ignored. A rise after HOLD ends gives left_ones = 2.
3. goal_left and goal_right rise in the same cycle during PLAY → scores unchanged, state remains PLAY.
4. Right scores 3 times with lockouts between → right_ones = 3, game_over = 1, winner = 1. right_darkN follows the pattern 1,1,0,0,1,1… and left_darkN = 1. Further goal edges leave the scores unchanged.
5. Assert new_game during GAME_OVER together with a goal_left rise → all digits 0, game_over = 0, both darkN = 1, state PLAY, and no goal is counted.
6. WIN_SCORE = 12: score left 10 times → left_tens = 1, left_ones = 0 (BCD carry). Pulse resetN low mid-HOLD → outputs return to reset values immediately.
